// File: rtl/ram_bank.sv
// ram_bank: parametrised single-port synchronous RAM with byte-lane write
// masking, registered read plus valid strobe, and a built-in clear engine.
module ram_bank #(
  parameter int unsigned     AW         = 3,
  parameter int unsigned     DEPTH      = 8,
  parameter int unsigned     DW         = 8,
  parameter int unsigned     LW         = 8,
  parameter logic [DW-1:0]   CLR_VAL    = '0,
  parameter bit              CLR_ON_RST = 1'b1
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               EN0,
  input  logic               WE0,
  input  logic [AW-1:0]      A0,
  input  logic [DW/LW-1:0]   WM0,
  input  logic [DW-1:0]      Di0,
  output logic [DW-1:0]      Do0,
  output logic               VLD0,
  input  logic               CLR,
  output logic               BUSY
);

  localparam int unsigned NL = DW / LW;
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            boot_q, boot_d;
  logic            vld_q, vld_d;
  logic [DW-1:0]   do_q, do_d;

  logic [DW-1:0]   mem [DEPTH];

  logic            in_range;
  logic            acc_ok;
  logic [IW-1:0]   acc_idx;
  logic [IW-1:0]   clr_idx;

  // Addresses at or above DEPTH never touch the array; the index is narrowed
  // to the array size only after the range check has qualified it.
  assign in_range = (32'(A0) < DEPTH);
  assign acc_ok   = (state_q == S_IDLE) && EN0;
  assign acc_idx  = IW'(A0);
  assign clr_idx  = IW'(cnt_q);

  // Next-state: sweep sequencing, post-reset kick-off and read pipeline.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    boot_d  = 1'b0;
    vld_d   = acc_ok && !WE0;
    do_d    = '0;
    if (vld_d && in_range) begin
      do_d = mem[acc_idx];
    end
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (CLR || (boot_q && CLR_ON_RST)) begin
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Control and output registers; asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      boot_q  <= 1'b1;
      vld_q   <= 1'b0;
      do_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      boot_q  <= boot_d;
      vld_q   <= vld_d;
      do_q    <= do_d;
    end
  end

  // Storage array: sweep writes take over the port while clearing; reset
  // deliberately leaves contents untouched.
  always_ff @(posedge CLK) begin
    if (state_q == S_CLEAR) begin
      mem[clr_idx] <= CLR_VAL;
    end else if (acc_ok && WE0 && in_range) begin
      for (int unsigned i = 0; i < NL; i++) begin
        if (WM0[i]) begin
          mem[acc_idx][i*LW +: LW] <= Di0[i*LW +: LW];
        end
      end
    end
  end

  assign Do0  = do_q;
  assign VLD0 = vld_q;
  assign BUSY = (state_q == S_CLEAR);

endmodule

// File: tb/tb_ram_bank.sv
// Directed bench for ram_bank: four configurations share one stimulus bus
// (defaults, 32-bit masked, CLR_VAL=0xFF, DEPTH=6 with out-of-range space).
module tb_ram_bank;

  logic        CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RST_N, EN, WE, CLR;
  logic [3:0]  A, WM;
  logic [31:0] DI;

  logic [7:0]  do0, do2, do3;
  logic [31:0] do1;
  logic        v0, v1, v2, v3;
  logic        b0, b1, b2, b3;

  int n_tests = 0;
  int n_fail  = 0;

  ram_bank u_d0 (
    .CLK(CLK), .RST_N(RST_N), .EN0(EN), .WE0(WE), .A0(A[2:0]), .WM0(WM[0:0]),
    .Di0(DI[7:0]), .Do0(do0), .VLD0(v0), .CLR(CLR), .BUSY(b0)
  );

  ram_bank #(.AW(4), .DEPTH(8), .DW(32), .LW(8)) u_d1 (
    .CLK(CLK), .RST_N(RST_N), .EN0(EN), .WE0(WE), .A0(A), .WM0(WM),
    .Di0(DI), .Do0(do1), .VLD0(v1), .CLR(CLR), .BUSY(b1)
  );

  ram_bank #(.CLR_VAL(8'hFF)) u_d2 (
    .CLK(CLK), .RST_N(RST_N), .EN0(EN), .WE0(WE), .A0(A[2:0]), .WM0(WM[0:0]),
    .Di0(DI[7:0]), .Do0(do2), .VLD0(v2), .CLR(CLR), .BUSY(b2)
  );

  ram_bank #(.AW(3), .DEPTH(6)) u_d3 (
    .CLK(CLK), .RST_N(RST_N), .EN0(EN), .WE0(WE), .A0(A[2:0]), .WM0(WM[0:0]),
    .Di0(DI[7:0]), .Do0(do3), .VLD0(v3), .CLR(CLR), .BUSY(b3)
  );

  typedef struct {
    logic        en;
    logic        we;
    logic [3:0]  a;
    logic [3:0]  wm;
    logic [31:0] di;
    logic        vld;
    logic [7:0]  e0;
    logic [31:0] e1;
    logic [7:0]  e2;
    logic [7:0]  e3;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(input logic en, input logic we, input logic [3:0] a,
                               input logic [3:0] wm, input logic [31:0] di,
                               input logic vld, input logic [7:0] e0,
                               input logic [31:0] e1, input logic [7:0] e2,
                               input logic [7:0] e3);
    vec_t v;
    v.en = en; v.we = we; v.a = a; v.wm = wm; v.di = di;
    v.vld = vld; v.e0 = e0; v.e1 = e1; v.e2 = e2; v.e3 = e3;
    return v;
  endfunction

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic we, input logic [3:0] a,
                       input logic [3:0] wm, input logic [31:0] di);
    EN = en; WE = we; A = a; WM = wm; DI = di;
  endtask

  task automatic check_all(input string tag, input logic vld, input logic [7:0] e0,
                           input logic [31:0] e1, input logic [7:0] e2,
                           input logic [7:0] e3);
    check({tag, ".vld0"}, 32'(v0), 32'(vld));
    check({tag, ".vld1"}, 32'(v1), 32'(vld));
    check({tag, ".vld2"}, 32'(v2), 32'(vld));
    check({tag, ".vld3"}, 32'(v3), 32'(vld));
    check({tag, ".do0"}, 32'(do0), 32'(e0));
    check({tag, ".do1"}, do1, e1);
    check({tag, ".do2"}, 32'(do2), 32'(e2));
    check({tag, ".do3"}, 32'(do3), 32'(e3));
  endtask

  // Samples BUSY of every instance over n cycles; f0 is d0's first sample.
  task automatic count_busy(input int n, output int c0, output int c1,
                            output int c2, output int c3, output logic f0);
    c0 = 0; c1 = 0; c2 = 0; c3 = 0; f0 = 1'b0;
    for (int k = 1; k <= n; k++) begin
      tick();
      if (k == 1) f0 = b0;
      c0 += int'(b0); c1 += int'(b1); c2 += int'(b2); c3 += int'(b3);
    end
  endtask

  task automatic check_sweep(input string tag);
    int c0, c1, c2, c3;
    logic f0;
    count_busy(12, c0, c1, c2, c3, f0);
    check({tag, ".first_edge_busy"}, 32'(f0), 32'd1);
    check({tag, ".busy_cycles0"}, 32'(c0), 32'd8);
    check({tag, ".busy_cycles1"}, 32'(c1), 32'd8);
    check({tag, ".busy_cycles2"}, 32'(c2), 32'd8);
    check({tag, ".busy_cycles3"}, 32'(c3), 32'd6);
  endtask

  task automatic read_cleared(input string tag);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 4'(i), 4'h0, 32'h0);
      tick();
      check_all($sformatf("%s.rd%0d", tag, i), 1'b1, 8'h00, 32'h0, 8'hFF, 8'h00);
    end
    drive(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1, c2, c3;
    logic f0;

    // Directed vectors; expected outputs are those seen after the edge.
    vecs.push_back(mkv(1, 1, 4'd2, 4'hF, 32'h0000005A, 0, 8'h00, 32'h0, 8'h00, 8'h00));
    vecs.push_back(mkv(1, 1, 4'd3, 4'hF, 32'h000000A5, 0, 8'h00, 32'h0, 8'h00, 8'h00));
    vecs.push_back(mkv(1, 0, 4'd2, 4'h0, 32'h0, 1, 8'h5A, 32'h0000005A, 8'h5A, 8'h5A));
    vecs.push_back(mkv(1, 0, 4'd3, 4'h0, 32'h0, 1, 8'hA5, 32'h000000A5, 8'hA5, 8'hA5));
    vecs.push_back(mkv(0, 0, 4'd3, 4'h0, 32'h0, 0, 8'h00, 32'h0, 8'h00, 8'h00));
    vecs.push_back(mkv(1, 1, 4'd5, 4'hF, 32'hAABBCCDD, 0, 8'h00, 32'h0, 8'h00, 8'h00));
    vecs.push_back(mkv(1, 1, 4'd5, 4'h5, 32'h11223344, 0, 8'h00, 32'h0, 8'h00, 8'h00));
    vecs.push_back(mkv(1, 0, 4'd5, 4'h0, 32'h0, 1, 8'h44, 32'hAA22CC44, 8'h44, 8'h44));
    vecs.push_back(mkv(1, 1, 4'd5, 4'h0, 32'hFFFFFFFF, 0, 8'h00, 32'h0, 8'h00, 8'h00));
    vecs.push_back(mkv(1, 0, 4'd5, 4'h0, 32'h0, 1, 8'h44, 32'hAA22CC44, 8'h44, 8'h44));
    vecs.push_back(mkv(1, 1, 4'd6, 4'hF, 32'h00000077, 0, 8'h00, 32'h0, 8'h00, 8'h00));
    vecs.push_back(mkv(1, 0, 4'd6, 4'h0, 32'h0, 1, 8'h77, 32'h00000077, 8'h77, 8'h00));
    vecs.push_back(mkv(1, 1, 4'd9, 4'hF, 32'h00000099, 0, 8'h00, 32'h0, 8'h00, 8'h00));
    vecs.push_back(mkv(1, 0, 4'd9, 4'h0, 32'h0, 1, 8'h99, 32'h0, 8'h99, 8'h99));
    vecs.push_back(mkv(1, 0, 4'd1, 4'h0, 32'h0, 1, 8'h99, 32'h0, 8'h99, 8'h99));
    vecs.push_back(mkv(1, 0, 4'd4, 4'h0, 32'h0, 1, 8'h00, 32'h0, 8'hFF, 8'h00));
    vecs.push_back(mkv(1, 1, 4'd7, 4'hF, 32'h0000003C, 0, 8'h00, 32'h0, 8'h00, 8'h00));
    vecs.push_back(mkv(1, 0, 4'd7, 4'h0, 32'h0, 1, 8'h3C, 32'h0000003C, 8'h3C, 8'h00));
    vecs.push_back(mkv(0, 0, 4'd0, 4'h0, 32'h0, 0, 8'h00, 32'h0, 8'h00, 8'h00));

    RST_N = 1'b0;
    CLR   = 1'b0;
    drive(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    repeat (2) tick();
    check("rst.busy0", 32'(b0), 32'd0);
    check("rst.busy3", 32'(b3), 32'd0);
    check_all("rst", 1'b0, 8'h00, 32'h0, 8'h00, 8'h00);

    // Power-on clear sweep.
    RST_N = 1'b1;
    #0;
    check("por.busy_before_edge", 32'(b0), 32'd0);
    check_sweep("por");
    read_cleared("por");

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].we, vecs[i].a, vecs[i].wm, vecs[i].di);
      tick();
      check_all($sformatf("vec%0d", i), vecs[i].vld, vecs[i].e0, vecs[i].e1,
                vecs[i].e2, vecs[i].e3);
    end

    // Clear request: write to addr 0 held during the sweep, a read slipped in,
    // and a second CLR mid-sweep that must not extend it.
    CLR = 1'b1;
    drive(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    c0 = 0; c2 = 0; c3 = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      c0 += int'(b0); c2 += int'(b2); c3 += int'(b3);
      if (k == 5) begin
        check("lock.rd_vld2", 32'(v2), 32'd0);
        check("lock.rd_do2", 32'(do2), 32'd0);
      end
      CLR = (k == 2);
      if (k == 4)      drive(1'b1, 1'b0, 4'h0, 4'h0, 32'h0);
      else if (k <= 8) drive(1'b1, 1'b1, 4'h0, 4'hF, 32'h00000012);
      else             drive(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    end
    check("lock.busy_cycles0", 32'(c0), 32'd8);
    check("lock.busy_cycles2", 32'(c2), 32'd8);
    check("lock.busy_cycles3", 32'(c3), 32'd6);
    drive(1'b1, 1'b0, 4'h0, 4'h0, 32'h0);
    tick();
    check_all("lock.rd0", 1'b1, 8'h00, 32'h0, 8'hFF, 8'h12);
    drive(1'b1, 1'b0, 4'h5, 4'h0, 32'h0);
    tick();
    check_all("lock.rd5", 1'b1, 8'h00, 32'h0, 8'hFF, 8'h00);

    // Read issued together with CLR still returns its pulse.
    drive(1'b1, 1'b1, 4'h7, 4'hF, 32'h0000005C);
    tick();
    CLR = 1'b1;
    drive(1'b1, 1'b0, 4'h7, 4'h0, 32'h0);
    tick();
    CLR = 1'b0;
    drive(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    check("clrrd.busy0", 32'(b0), 32'd1);
    check_all("clrrd", 1'b1, 8'h5C, 32'h0000005C, 8'h5C, 8'h00);
    tick();
    check("clrrd.vld_after", 32'(v0), 32'd0);
    tick();

    // Reset at sweep cycle 3: asynchronous drop, then full rerun.
    check("midrst.busy_before", 32'(b2), 32'd1);
    RST_N = 1'b0;
    #1;
    check("midrst.busy0", 32'(b0), 32'd0);
    check("midrst.busy2", 32'(b2), 32'd0);
    check_all("midrst", 1'b0, 8'h00, 32'h0, 8'h00, 8'h00);
    tick();
    check("midrst.busy_held", 32'(b0), 32'd0);
    RST_N = 1'b1;
    check_sweep("rerun");
    read_cleared("rerun");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_bank.md
Name: ram_bank

Overview:
- Parametrised single-port synchronous RAM. Successor to the fixed 8x8 combinational-read RAM macro.
- Adds configurable width and depth, byte-lane write masking, and a registered read with a valid strobe.
- Adds a built-in clear engine that sweeps every word to a fixed value after reset or on request.
- Used as the general scratch/register-file store in the core datapath. Slots in where the 8x8 RAM sat.

Parameters:
- AW, 3, address width in bits.
- DEPTH, 8, number of words; must satisfy 1 <= DEPTH <= 2**AW.
- DW, 8, data word width in bits; must be a multiple of LW.
- LW, 8, write-lane width in bits; NL = DW/LW lanes.
- CLR_VAL, 0, DW-bit value written to every word by the clear engine.
- CLR_ON_RST, 1, 1 = run a clear sweep automatically after reset deassertion.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST_N  input  1  reset, asynchronous assert, active-low.
- EN0  input  1  access request, sampled each cycle.
- WE0  input  1  1 = write, 0 = read; qualified by EN0.
- A0  input  AW  word address.
- WM0  input  NL  per-lane write mask; bit i enables Di0[i*LW +: LW].
- Di0  input  DW  write data.
- Do0  output  DW  read data, registered.
- VLD0  output  1  Do0 holds valid read data this cycle.
- CLR  input  1  single-cycle request to start a clear sweep.
- BUSY  output  1  clear sweep in progress; accesses ignored.

Behaviour:
- Reset (RST_N low, asynchronous):
  - Do0 = 0, VLD0 = 0, FSM = IDLE, sweep counter = 0.
  - BUSY = 0.
  - Memory contents are not touched by reset.
- On the first clock edge after deassertion with CLR_ON_RST = 1, the FSM enters CLEAR and BUSY = 1.
- FSM states:
  - IDLE -> CLEAR: on (CLR = 1), or on the first edge after reset deassertion when CLR_ON_RST = 1.
  - CLEAR: each cycle, writes CLR_VAL to mem[cnt] (all lanes) and increments cnt.
  - CLEAR -> IDLE: after the cycle that writes address DEPTH-1. cnt returns to 0; BUSY = 0 from the next cycle.
  - A sweep takes exactly DEPTH cycles with BUSY high.
  - CLR asserted during CLEAR is ignored; no restart and no extension.
- While BUSY = 1, EN0 is ignored: no write, no read, VLD0 = 0.
- Write, when IDLE and EN0 & WE0:
  - On the edge, lanes with WM0[i] = 1 are updated; other lanes retain their value.
  - WM0 = 0 is a legal no-op.
  - VLD0 = 0 in the following cycle.
- Read, when IDLE and EN0 & ~WE0:
  - Fixed latency of 1. On the next cycle Do0 = mem[A0] and VLD0 = 1.
  - VLD0 is high for exactly one cycle per request.
  - Back-to-back reads give back-to-back VLD0 pulses.
- Do0 is forced to 0 in any cycle where VLD0 = 0; no stale data is presented.
- Read after write: a read issued the cycle after a write to the same address returns the newly written lanes.
- Out-of-range address (A0 >= DEPTH, only possible when DEPTH < 2**AW):
  - Writes are dropped.
  - Reads return Do0 = 0 with VLD0 = 1.
- CLR in the same cycle as EN0 (FSM in IDLE): the access is performed normally and CLEAR starts on that edge.
  - A read issued in that cycle still produces its VLD0 pulse in the next cycle, even though BUSY is then 1.
- Reset asserted mid-sweep: FSM aborts to the reset state and the partially cleared memory is left as is. With CLR_ON_RST = 1 the sweep restarts from address 0 after deassertion.
- No combinational path from inputs to outputs.

Test Plan:
- Power-on clear (defaults): release RST_N -> BUSY high for exactly 8 cycles starting the edge after release; afterwards reading each of addresses 0..7 returns Do0 = 0x00 with VLD0 = 1 one cycle after each request.
- Masked write (DW = 32, LW = 8, AW = 4): write 0xAABBCCDD to addr 5 with WM0 = 4'b1111, then write 0x11223344 with WM0 = 4'b0101 -> read addr 5 gives 0xAA22CC44.
- Read timing and gating: writes 0x5A @ 2 and 0xA5 @ 3, then reads @ 2 and @ 3 on consecutive cycles -> Do0 = 0x5A then 0xA5 on consecutive cycles with VLD0 = 1,1; the following idle cycle gives Do0 = 0x00, VLD0 = 0.
- Clear request with lockout (CLR_VAL = 0xFF): pulse CLR, then drive EN0 & WE0 to addr 0 with 0x12 during BUSY -> write ignored, BUSY high 8 cycles; afterwards addr 0 reads 0xFF.
- Out of range (AW = 3, DEPTH = 6): write 0x77 @ 6, then read @ 6 -> Do0 = 0x00, VLD0 = 1; addresses 0..5 are unaffected.
- Reset mid-sweep: assert RST_N low at sweep cycle 3 -> Do0 = 0, VLD0 = 0, BUSY = 0 immediately, without waiting for a clock edge; after release the sweep reruns over the full 8 cycles and all words read CLR_VAL.
